// File: rtl/image_bank.sv
// Multi-slot frame store with a registered display output. Writes land in a slot
// at the sampling edge; display switches between slots only on frame_tick.
module image_bank #(
  parameter int SCREEN_SIZE = 8,
  parameter int NUM_SLOTS   = 2,
  parameter int SLOT_BITS   = 1,
  localparam int WIDTH      = SCREEN_SIZE * 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 draw,
  input  logic [1:0]           draw_mode,
  input  logic [SLOT_BITS-1:0] draw_slot,
  input  logic [WIDTH-1:0]     draw_image,
  input  logic                 show,
  input  logic [SLOT_BITS-1:0] show_slot,
  input  logic                 frame_tick,
  output logic [WIDTH-1:0]     image,
  output logic [SLOT_BITS-1:0] shown_slot,
  output logic                 show_pending,
  output logic                 draw_ack
);

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_OR    = 2'b01,
    MODE_ERASE = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  localparam logic [SLOT_BITS:0] SLOT_LIMIT = (SLOT_BITS + 1)'(NUM_SLOTS);

  logic [WIDTH-1:0]     slots_q [NUM_SLOTS];
  logic [WIDTH-1:0]     slots_d [NUM_SLOTS];
  logic [WIDTH-1:0]     image_q, image_d;
  logic [SLOT_BITS-1:0] shown_q, shown_d;
  logic [SLOT_BITS-1:0] pend_slot_q, pend_slot_d;
  logic                 pend_q, pend_d;
  logic                 ack_q, ack_d;

  logic                 wr_en;
  logic                 show_ok;
  logic [WIDTH-1:0]     wr_val;

  assign wr_en   = draw && ({1'b0, draw_slot} < SLOT_LIMIT);
  assign show_ok = show && ({1'b0, show_slot} < SLOT_LIMIT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    slots_d     = slots_q;
    shown_d     = shown_q;
    pend_d      = pend_q;
    pend_slot_d = pend_slot_q;
    ack_d       = wr_en;
    wr_val      = '0;

    if (wr_en) begin
      case (mode_e'(draw_mode))
        MODE_LOAD:  wr_val = draw_image;
        MODE_OR:    wr_val = slots_q[draw_slot] | draw_image;
        MODE_ERASE: wr_val = slots_q[draw_slot] & ~draw_image;
        default:    wr_val = '0;
      endcase
      slots_d[draw_slot] = wr_val;
    end

    // A request arriving with the tick supersedes any older pending one.
    if (frame_tick) begin
      if (show_ok) begin
        shown_d = show_slot;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        shown_d = pend_slot_q;
        pend_d  = 1'b0;
      end
    end else if (show_ok) begin
      pend_slot_d = show_slot;
      pend_d      = 1'b1;
    end

    // Mirror the post-edge contents of the post-edge slot, so same-cycle writes show up.
    image_d = slots_d[shown_d];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      // NOTE: the slot storage is reset because a cleared bank is architecturally visible.
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
      image_q     <= '0;
      shown_q     <= '0;
      pend_slot_q <= '0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      slots_q     <= slots_d;
      image_q     <= image_d;
      shown_q     <= shown_d;
      pend_slot_q <= pend_slot_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
    end
  end

  assign image        = image_q;
  assign shown_slot   = shown_q;
  assign show_pending = pend_q;
  assign draw_ack     = ack_q;

endmodule

// File: tb/tb_image_bank.sv
// Directed table-driven bench for image_bank with 3 slots of 32-bit frames,
// plus short hand sequences for ack pulse width and held reset.
module tb_image_bank;

  localparam int SCREEN_SIZE = 4;
  localparam int NUM_SLOTS   = 3;
  localparam int SLOT_BITS   = 2;
  localparam int WIDTH       = SCREEN_SIZE * 8;

  localparam logic [1:0] LD = 2'b00, OR = 2'b01, ER = 2'b10, CL = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst, draw, show, frame_tick;
  logic [1:0]           draw_mode;
  logic [SLOT_BITS-1:0] draw_slot, show_slot;
  logic [WIDTH-1:0]     draw_image;
  logic [WIDTH-1:0]     image;
  logic [SLOT_BITS-1:0] shown_slot;
  logic                 show_pending, draw_ack;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       draw;
    logic [1:0] mode;
    logic [1:0] dslot;
    logic [31:0] dimg;
    logic       show;
    logic [1:0] sslot;
    logic       tick;
    logic [31:0] e_img;
    logic [1:0] e_shown;
    logic       e_pend;
    logic       e_ack;
  } vec_t;

  vec_t vq[$];

  image_bank #(
    .SCREEN_SIZE(SCREEN_SIZE),
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_BITS  (SLOT_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .draw        (draw),
    .draw_mode   (draw_mode),
    .draw_slot   (draw_slot),
    .draw_image  (draw_image),
    .show        (show),
    .show_slot   (show_slot),
    .frame_tick  (frame_tick),
    .image       (image),
    .shown_slot  (shown_slot),
    .show_pending(show_pending),
    .draw_ack    (draw_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst;
    draw       = v.draw;
    draw_mode  = v.mode;
    draw_slot  = v.dslot;
    draw_image = v.dimg;
    show       = v.show;
    show_slot  = v.sslot;
    frame_tick = v.tick;
  endtask

  task automatic idle();
    rst = 0; draw = 0; draw_mode = LD; draw_slot = 0; draw_image = '0;
    show = 0; show_slot = 0; frame_tick = 0;
  endtask

  initial begin
    // rst draw mode dslot dimg         show sslot tick | image        shown pend ack
    vq.push_back('{1, 0, LD, 0, 32'h0,        0, 0, 0,   32'h0,        0, 0, 0}); // 0 reset
    vq.push_back('{0, 1, LD, 0, 32'h000000FF, 0, 0, 0,   32'h000000FF, 0, 0, 1}); // 1 load shown slot
    vq.push_back('{0, 0, LD, 0, 32'h0,        0, 0, 0,   32'h000000FF, 0, 0, 0}); // 2 ack drops
    vq.push_back('{0, 1, LD, 1, 32'h0F0F0F0F, 0, 0, 0,   32'h000000FF, 0, 0, 1}); // 3
    vq.push_back('{0, 1, OR, 1, 32'hF0000000, 0, 0, 0,   32'h000000FF, 0, 0, 1}); // 4
    vq.push_back('{0, 1, ER, 1, 32'h0000000F, 0, 0, 0,   32'h000000FF, 0, 0, 1}); // 5 slot1=FF0F0F00
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 1, 0,   32'h000000FF, 0, 1, 0}); // 6 pend s1
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 2, 0,   32'h000000FF, 0, 1, 0}); // 7 last wins s2
    vq.push_back('{0, 0, LD, 0, 32'h0,        0, 0, 1,   32'h0,        2, 0, 0}); // 8 tick -> s2
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 1, 1,   32'hFF0F0F00, 1, 0, 0}); // 9 show+tick s1
    vq.push_back('{0, 1, LD, 3, 32'hFFFFFFFF, 0, 0, 0,   32'hFF0F0F00, 1, 0, 0}); // 10 draw s3 ignored
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 0, 0,   32'hFF0F0F00, 1, 1, 0}); // 11 pend s0
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 3, 0,   32'hFF0F0F00, 1, 1, 0}); // 12 show s3 ignored
    vq.push_back('{0, 1, CL, 1, 32'hFFFFFFFF, 0, 0, 1,   32'h000000FF, 0, 0, 1}); // 13 clear old + switch
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 1, 1,   32'h0,        1, 0, 0}); // 14 slot1 cleared
    vq.push_back('{0, 1, OR, 1, 32'h0000A500, 0, 0, 0,   32'h0000A500, 1, 0, 1}); // 15 write to shown
    vq.push_back('{0, 0, LD, 0, 32'h0,        0, 0, 1,   32'h0000A500, 1, 0, 0}); // 16 tick, none pending
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 1, 0,   32'h0000A500, 1, 1, 0}); // 17 re-request shown
    vq.push_back('{0, 0, LD, 0, 32'h0,        0, 0, 1,   32'h0000A500, 1, 0, 0}); // 18
    vq.push_back('{0, 1, LD, 0, 32'h12345678, 1, 0, 1,   32'h12345678, 0, 0, 1}); // 19 write new slot + switch
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 2, 0,   32'h12345678, 0, 1, 0}); // 20 pend s2
    vq.push_back('{1, 1, LD, 2, 32'hDEADBEEF, 1, 1, 1,   32'h0,        0, 0, 0}); // 21 reset overrides
    vq.push_back('{0, 0, LD, 0, 32'h0,        0, 0, 1,   32'h0,        0, 0, 0}); // 22 pending discarded
    vq.push_back('{0, 0, LD, 0, 32'h0,        1, 2, 1,   32'h0,        2, 0, 0}); // 23 no write in reset
    vq.push_back('{0, 1, LD, 2, 32'h00000011, 0, 0, 0,   32'h00000011, 2, 0, 1}); // 24 back-to-back
    vq.push_back('{0, 1, ER, 2, 32'h00000001, 0, 0, 0,   32'h00000010, 2, 0, 1}); // 25
    vq.push_back('{0, 1, CL, 2, 32'hFFFFFFFF, 0, 0, 0,   32'h0,        2, 0, 1}); // 26
    vq.push_back('{0, 1, OR, 0, 32'h0,        0, 0, 1,   32'h0,        2, 0, 1}); // 27 slot0 still 0 after reset

    idle();
    @(negedge clk);
    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d image", i),        image,                 vq[i].e_img);
      check($sformatf("v%0d shown_slot", i),   32'(shown_slot),       32'(vq[i].e_shown));
      check($sformatf("v%0d show_pending", i), 32'(show_pending),     32'(vq[i].e_pend));
      check($sformatf("v%0d draw_ack", i),     32'(draw_ack),         32'(vq[i].e_ack));
      @(negedge clk);
    end

    // Single write: ack high for exactly one cycle, image changes only at the edge.
    idle();
    draw = 1; draw_mode = LD; draw_slot = 2; draw_image = 32'hCAFE0001;
    #2;
    check("pre-edge image", image, 32'h0);
    @(posedge clk); #1;
    idle();
    check("seq ack pulse", 32'(draw_ack), 32'd1);
    check("seq image", image, 32'hCAFE0001);
    @(posedge clk); #1;
    check("seq ack low", 32'(draw_ack), 32'd0);

    // Reset held for two cycles with a write and a pending show, then normal use.
    @(negedge clk);
    show = 1; show_slot = 1;
    @(negedge clk);
    check("seq pend set", 32'(show_pending), 32'd1);
    rst = 1; show = 0; draw = 1; draw_mode = OR; draw_slot = 2; draw_image = 32'h0000FFFF;
    repeat (2) @(posedge clk);
    #1;
    check("seq rst image", image, 32'h0);
    check("seq rst pend", 32'(show_pending), 32'd0);
    check("seq rst ack", 32'(draw_ack), 32'd0);
    @(negedge clk);
    idle();
    show = 1; show_slot = 2; frame_tick = 1;
    @(posedge clk); #1;
    idle();
    check("seq post-rst shown", 32'(shown_slot), 32'd2);
    check("seq post-rst slot2", image, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/image_bank.md
IMAGE_BANK -- requirements
Module: image_bank

Interface
- REQ-001: Parameter SCREEN_SIZE, default 8, number of 8-bit screen rows; WIDTH = SCREEN_SIZE*8 bits per frame.
- REQ-002: Parameter NUM_SLOTS, default 2, number of stored frames; legal range 2..16.
- REQ-003: Parameter SLOT_BITS, default 1, slot index width; SHALL satisfy 2**SLOT_BITS >= NUM_SLOTS.
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: rst  input  1  reset, synchronous and active-high.
- REQ-006: draw  input  1  write strobe, one write per asserted cycle.
- REQ-007: draw_mode  input  2  00 LOAD, 01 OR-merge, 10 ERASE (clear bits set in draw_image), 11 CLEAR (zero slot).
- REQ-008: draw_slot  input  SLOT_BITS  target slot of the write.
- REQ-009: draw_image  input  WIDTH  write data; ignored in CLEAR mode.
- REQ-010: show  input  1  request to display show_slot.
- REQ-011: show_slot  input  SLOT_BITS  slot requested for display.
- REQ-012: frame_tick  input  1  frame boundary strobe; display switches only here.
- REQ-013: image  output  WIDTH  registered copy of the displayed slot.
- REQ-014: shown_slot  output  SLOT_BITS  index of the displayed slot.
- REQ-015: show_pending  output  1  a display switch awaits the next frame_tick.
- REQ-016: draw_ack  output  1  one-cycle pulse, cycle after an accepted write.

Function
- REQ-017: Write accepted when draw=1 and draw_slot < NUM_SLOTS; out-of-range draw_slot SHALL leave all state unchanged and give no ack.
- REQ-018: Accepted write sampled at edge N SHALL update the slot at edge N: LOAD slot<=d; OR slot<=slot|d; ERASE slot<=slot&~d; CLEAR slot<=0.
- REQ-019: draw_ack SHALL be 1 in the cycle following edge N, for exactly one cycle per accepted write; back-to-back writes give back-to-back acks.
- REQ-020: image SHALL always equal the shown slot's contents after each edge; a write to the shown slot SHALL appear on image at the same edge N (no extra latency).
- REQ-021: show=1 with in-range show_slot and frame_tick=0 SHALL store the request and set show_pending=1; a later show before the tick overwrites it (last wins).
- REQ-022: Out-of-range show_slot SHALL be ignored; any existing pending request is kept.
- REQ-023: frame_tick=1 with a pending request SHALL set shown_slot to the pending slot, load image with that slot's contents, and clear show_pending, all at that edge.
- REQ-024: show and frame_tick in the same cycle: the new request SHALL take effect at that edge, superseding any older pending one; show_pending stays 0.
- REQ-025: frame_tick with no pending request SHALL change nothing.
- REQ-026: Write and display switch in the same cycle: image SHALL reflect the new slot including that cycle's write when it targets the new slot; a write to the old slot updates storage only.
- REQ-027: Requesting the already-shown slot is legal; it pends and applies at the tick with no visible image change.

Reset
- REQ-028: rst=1 at an edge SHALL zero every slot, image, shown_slot, show_pending and draw_ack, overriding draw, show and frame_tick that cycle.
- REQ-029: rst asserted while a request is pending SHALL discard it; a write sampled with rst=1 is not performed and not acked.
- REQ-030: After rst deasserts, the first edge SHALL accept draw/show normally.

Verification (SCREEN_SIZE=4, NUM_SLOTS=3, SLOT_BITS=2)
- REQ-031: reset; LOAD slot0 0x000000FF -> same edge image=0x000000FF; next cycle draw_ack=1 for one cycle.
- REQ-032: LOAD slot1 0x0F0F0F0F, OR slot1 0xF0000000, ERASE slot1 0x0000000F -> slot1=0xFF0F0F00; image unchanged (slot0 shown).
- REQ-033: show slot1, then show slot2, then frame_tick -> show_pending 1 until the tick, then shown_slot=2 and image=0; show and frame_tick together on slot1 -> shown_slot=1 at that edge, image=0xFF0F0F00, show_pending=0.
- REQ-034: draw slot3 or show slot3 -> no state change, draw_ack=0, show_pending unaffected.
- REQ-035: slot1 shown, CLEAR slot1 in the same cycle as a switch to slot0 -> image=0x000000FF, slot1=0; a second switch to slot1 then shows image=0.
- REQ-036: pending show plus draw asserted with rst=1 -> all outputs 0, no ack next cycle, later frame_tick with no show leaves shown_slot=0.
